// File: rtl/ltm_pkg.sv
// ltm_pkg: shared types and default raster timing for the LTM scanout path.
//   scan_state_t   : stream alignment state of the scanout engine
//   *_DEF          : default 800x480 panel timing
//   timing_total() : line or frame total from its four segment lengths
package ltm_pkg;

  typedef enum logic [1:0] {
    DROP   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } scan_state_t;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FRONT_DEF  = 40;
  localparam int H_SYNC_DEF   = 1;
  localparam int H_BACK_DEF   = 215;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 1;
  localparam int V_BACK_DEF   = 34;

  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/ltm_scanout_raster_counter.sv
// raster_counter: free-running h/v position counters and raster decode.
//   clk, reset_n : scanout clock, async active-low reset (restarts at origin)
//   active       : current position is a visible pixel
//   origin       : current position is (0,0)
//   hd_n, vd_n   : sync levels for the current position (active low)
//   vblank       : first clock of the first non-active line
// Order within a line/frame: active, front porch, sync, back porch.
module raster_counter import ltm_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic active,
  output logic origin,
  output logic hd_n,
  output logic vd_n,
  output logic vblank
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  // Decode constants are kept 32 bits wide so the sync end (which may equal
  // the total) never truncates into the counter width.
  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] H_SYNC_S = 32'(H_ACTIVE + H_FRONT);
  localparam logic [31:0] H_SYNC_E = 32'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [31:0] V_SYNC_S = 32'(V_ACTIVE + V_FRONT);
  localparam logic [31:0] V_SYNC_E = 32'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   h_ext;
  logic [31:0]   v_ext;

  assign h_ext = 32'(h_cnt);
  assign v_ext = 32'(v_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_ext == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_ext == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign active = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign origin = (h_cnt == '0) && (v_cnt == '0);
  assign hd_n   = !((h_ext >= H_SYNC_S) && (h_ext < H_SYNC_E));
  assign vd_n   = !((v_ext >= V_SYNC_S) && (v_ext < V_SYNC_E));
  assign vblank = (h_cnt == '0) && (v_ext == V_ACT);

endmodule

// File: rtl/ltm_scanout.sv
// ltm_scanout: fixed-timing scanout engine for the LTM panel.
//   clk, reset_n              : scanout clock, async active-low reset
//   in_data/in_valid/in_ready : Avalon-ST 24-bit RGB pixel stream
//   in_startofpacket          : first pixel of a frame
//   ltm_r/g/b, ltm_den        : panel colour and data enable (registered)
//   ltm_hd, ltm_vd            : panel syncs, active low (registered)
//   vblank_start              : one-clock pulse at first non-active line
//   underflow_count           : saturating count of starved active pixels
//   sync_err_count            : saturating count of frame alignment errors
//   dbg_state                 : current stream alignment state
//
// Handshake: a pixel transfers on a clock edge where in_valid && in_ready.
// in_ready is combinational from state, raster position, in_valid and
// in_startofpacket; the source must hold in_data/in_startofpacket stable
// while in_valid is high and the pixel has not transferred.
//
// The raster free-runs regardless of the stream so the panel never loses
// sync; the stream is only ever aligned to it by throwing pixels away
// (DROP) or by holding a start-of-frame pixel until origin (ARMED).
module ltm_scanout import ltm_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  output logic        in_ready,
  output logic [7:0]  ltm_r,
  output logic [7:0]  ltm_g,
  output logic [7:0]  ltm_b,
  output logic        ltm_den,
  output logic        ltm_hd,
  output logic        ltm_vd,
  output logic        vblank_start,
  output logic [15:0] underflow_count,
  output logic [15:0] sync_err_count,
  output scan_state_t dbg_state
);

  logic        active;
  logic        origin;
  logic        hd_n;
  logic        vd_n;
  logic        vblank;

  scan_state_t state;
  logic        err_origin;
  logic        err_early;
  logic        starve;
  logic        consume;
  logic [23:0] pix;

  raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_raster (
    .clk    (clk),
    .reset_n(reset_n),
    .active (active),
    .origin (origin),
    .hd_n   (hd_n),
    .vd_n   (vd_n),
    .vblank (vblank)
  );

  always_comb begin
    err_origin = 1'b0;
    err_early  = 1'b0;
    starve     = 1'b0;
    in_ready   = 1'b0;
    case (state)
      // Discard everything up to the next start of frame.
      DROP:   in_ready = in_valid && !in_startofpacket;
      // SOP pixel waits at the stream head until the raster reaches origin.
      ARMED:  in_ready = origin;
      STREAM: begin
        // A frame that does not start at origin, or a SOP arriving inside the
        // visible area, means the stream slipped against the raster.
        err_origin = in_valid && origin && !in_startofpacket;
        err_early  = in_valid && active && !origin && in_startofpacket;
        in_ready   = active && !err_origin && !err_early;
        starve     = active && !in_valid;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign consume = in_valid && in_ready;
  // Pixels swallowed in DROP are never shown; everything unconsumed is black.
  assign pix     = (consume && (state != DROP)) ? in_data : 24'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= DROP;
      ltm_r           <= 8'h0;
      ltm_g           <= 8'h0;
      ltm_b           <= 8'h0;
      ltm_den         <= 1'b0;
      ltm_hd          <= 1'b1;
      ltm_vd          <= 1'b1;
      vblank_start    <= 1'b0;
      underflow_count <= 16'h0;
      sync_err_count  <= 16'h0;
    end else begin
      ltm_r        <= pix[23:16];
      ltm_g        <= pix[15:8];
      ltm_b        <= pix[7:0];
      ltm_den      <= active;
      ltm_hd       <= hd_n;
      ltm_vd       <= vd_n;
      vblank_start <= vblank;

      if (starve && (underflow_count != 16'hFFFF))
        underflow_count <= underflow_count + 16'd1;
      if ((err_origin || err_early) && (sync_err_count != 16'hFFFF))
        sync_err_count <= sync_err_count + 16'd1;

      case (state)
        DROP:    if (in_valid && in_startofpacket) state <= ARMED;
        ARMED:   if (origin && in_valid) state <= STREAM;
        STREAM: begin
          if (err_origin)     state <= DROP;
          else if (err_early) state <= ARMED;
        end
        default: state <= DROP;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ltm_scanout.sv
// tb_ltm_scanout: self-checking bench for ltm_scanout.
// dut  : small raster (16x8 active, 22x13 total) for function checks.
// dut2 : 64x32 active with one-clock porches, used for counter saturation.
module tb_ltm_scanout;
  import ltm_pkg::*;

  localparam int HA = 16, HF = 2, HS = 1, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 22
  localparam int VT = VA + VF + VS + VB;   // 13
  localparam int FT = HT * VT;             // 286 clocks per frame
  localparam int FPIX = HA * VA;           // 128 pixels per frame

  localparam int S_HA = 64, S_VA = 32;
  localparam int S_HT = S_HA + 3;
  localparam int S_VT = S_VA + 3;
  localparam int S_FT = S_HT * S_VT;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, reset2_n;
  logic [23:0] in_data, data2;
  logic        in_valid, in_startofpacket, in_ready;
  logic        valid2, sop2, ready2;
  logic [7:0]  ltm_r, ltm_g, ltm_b, r2, g2, b2;
  logic        ltm_den, ltm_hd, ltm_vd, vblank_start;
  logic        den2, hd2, vd2, vb2;
  logic [15:0] underflow_count, sync_err_count, uf2, se2;
  scan_state_t dbg_state, dbg2;

  ltm_scanout #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_ready(in_ready),
    .ltm_r(ltm_r), .ltm_g(ltm_g), .ltm_b(ltm_b), .ltm_den(ltm_den),
    .ltm_hd(ltm_hd), .ltm_vd(ltm_vd), .vblank_start(vblank_start),
    .underflow_count(underflow_count), .sync_err_count(sync_err_count),
    .dbg_state(dbg_state)
  );

  ltm_scanout #(
    .H_ACTIVE(S_HA), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(S_VA), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut2 (
    .clk(clk), .reset_n(reset2_n), .in_data(data2), .in_valid(valid2),
    .in_startofpacket(sop2), .in_ready(ready2),
    .ltm_r(r2), .ltm_g(g2), .ltm_b(b2), .ltm_den(den2),
    .ltm_hd(hd2), .ltm_vd(vd2), .vblank_start(vb2),
    .underflow_count(uf2), .sync_err_count(se2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit sat_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position is the frame-relative clock index; h/v come from division.
  // mode: 0 = discarding, 1 = waiting for origin with SOP, 2 = streaming.
  int          pos, last_pos, mode, m_uf, m_se;
  logic [23:0] e_pix;
  logic        e_den, e_hd, e_vd, e_vb;

  // stream source: frame of FPIX pixels, index 0 carries SOP
  int          src_idx;
  logic [23:0] head_data, sop_force;
  bit          sop_force_en, valid_en, rnd_en;

  task automatic model_reset();
    pos = 0; last_pos = -1; mode = 0; m_uf = 0; m_se = 0;
    e_pix = '0; e_den = 0; e_hd = 1; e_vd = 1; e_vb = 0;
  endtask

  task automatic src_advance();
    src_idx = (src_idx + 1) % FPIX;
    if (rnd_en && ($urandom_range(0, 199) == 0)) src_idx = 0;
    if (src_idx == 0 && sop_force_en) begin
      head_data = sop_force;
      sop_force_en = 0;
    end else begin
      head_data = 24'($urandom);
    end
  endtask

  // Called at a negedge: drive, predict, check in_ready, clock, check outputs.
  task automatic tick();
    int h, v, nmode;
    bit act, org, rdy, uf, err;
    logic [23:0] pix;
    if (rnd_en) valid_en = ($urandom_range(0, 7) != 0);
    in_valid = valid_en;
    in_data = head_data;
    in_startofpacket = (src_idx == 0);
    h = pos % HT;
    v = pos / HT;
    act = (h < HA) && (v < VA);
    org = (pos == 0);
    nmode = mode; rdy = 0; uf = 0; err = 0; pix = '0;
    if (mode == 0) begin
      rdy = in_valid && !in_startofpacket;
      if (in_valid && in_startofpacket) nmode = 1;
    end else if (mode == 1) begin
      rdy = org;
      if (org && in_valid) begin pix = in_data; nmode = 2; end
    end else begin
      if (in_valid && org && !in_startofpacket) begin err = 1; nmode = 0; end
      else if (in_valid && act && !org && in_startofpacket) begin err = 1; nmode = 1; end
      else rdy = act;
      if (act && !in_valid) uf = 1;
      if (rdy && in_valid) pix = in_data;
    end
    #1;
    check("in_ready", in_ready, rdy);
    @(posedge clk);
    #1;
    mode = nmode;
    if (uf && m_uf < 65535) m_uf++;
    if (err && m_se < 65535) m_se++;
    e_pix = pix;
    e_den = act;
    e_hd = !(h >= HA + HF && h < HA + HF + HS);
    e_vd = !(v >= VA + VF && v < VA + VF + VS);
    e_vb = (h == 0) && (v == VA);
    last_pos = pos;
    pos = (pos + 1) % FT;
    if (rdy && in_valid) src_advance();
    check("rgb", {ltm_r, ltm_g, ltm_b}, e_pix);
    check("den", ltm_den, e_den);
    check("hd", ltm_hd, e_hd);
    check("vd", ltm_vd, e_vd);
    check("vblank", vblank_start, e_vb);
    check("underflow", underflow_count, m_uf);
    check("sync_err", sync_err_count, m_se);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases on a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 0;
    valid_en = 0; in_valid = 0; in_startofpacket = 0; in_data = '0;
    #1;
    check("rst_den", ltm_den, 1'b0);
    check("rst_hd", ltm_hd, 1'b1);
    check("rst_vd", ltm_vd, 1'b1);
    check("rst_vblank", vblank_start, 1'b0);
    check("rst_rgb", {ltm_r, ltm_g, ltm_b}, 24'h0);
    check("rst_uf", underflow_count, 16'h0);
    check("rst_se", sync_err_count, 16'h0);
    check("rst_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  // Tick until the model has just evaluated the given position in streaming mode.
  task automatic run_to(input int target, input bit need_stream, input string name);
    int n;
    n = 0;
    while (!(last_pos == target && (!need_stream || mode == 2)) && n < 3 * FT) begin
      tick();
      n++;
    end
    if (n >= 3 * FT) check(name, 32'd0, 32'd1);
  endtask

  typedef struct {
    int   h;
    int   v;
    logic den;
    logic hd;
    logic vd;
    logic vb;
  } vec_t;
  vec_t tbl [17];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset_n = 1; in_valid = 0; in_startofpacket = 0; in_data = '0;
    valid_en = 0; rnd_en = 0; sop_force_en = 0; src_idx = 0; head_data = '0;
    model_reset();

    // raster decode table: {h, v, den, hd, vd, vblank}, outputs one clock later
    tbl[0]  = '{0, 0, 1, 1, 1, 0};
    tbl[1]  = '{15, 0, 1, 1, 1, 0};
    tbl[2]  = '{16, 0, 0, 1, 1, 0};
    tbl[3]  = '{17, 0, 0, 1, 1, 0};
    tbl[4]  = '{18, 0, 0, 0, 1, 0};
    tbl[5]  = '{19, 0, 0, 1, 1, 0};
    tbl[6]  = '{21, 0, 0, 1, 1, 0};
    tbl[7]  = '{0, 1, 1, 1, 1, 0};
    tbl[8]  = '{15, 7, 1, 1, 1, 0};
    tbl[9]  = '{0, 8, 0, 1, 1, 1};
    tbl[10] = '{1, 8, 0, 1, 1, 0};
    tbl[11] = '{21, 9, 0, 1, 1, 0};
    tbl[12] = '{0, 10, 0, 1, 0, 0};
    tbl[13] = '{18, 10, 0, 0, 0, 0};
    tbl[14] = '{21, 10, 0, 1, 0, 0};
    tbl[15] = '{0, 11, 0, 1, 1, 0};
    tbl[16] = '{18, 12, 0, 0, 1, 0};

    // raster timing with an idle stream
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_to(tbl[i].v * HT + tbl[i].h, 1'b0, "tbl_timeout");
      check($sformatf("tbl%0d_den", i), ltm_den, tbl[i].den);
      check($sformatf("tbl%0d_hd", i), ltm_hd, tbl[i].hd);
      check($sformatf("tbl%0d_vd", i), ltm_vd, tbl[i].vd);
      check($sformatf("tbl%0d_vb", i), vblank_start, tbl[i].vb);
    end

    // continuous aligned stream, first SOP shown at origin of frame 1
    do_reset();
    src_idx = 0; head_data = 24'h123456; valid_en = 1;
    run_to(0, 1'b1, "origin_timeout");
    check("origin_pixel", {ltm_r, ltm_g, ltm_b}, 24'h123456);
    for (int i = 0; i < 2 * FT - 1; i++) tick();
    check("clean_uf", underflow_count, 16'd0);
    check("clean_se", sync_err_count, 16'd0);

    // starvation: 5 missing pixels mid-line
    run_to(3 * HT + 4, 1'b1, "starve_timeout");
    valid_en = 0;
    for (int i = 0; i < 5; i++) tick();
    valid_en = 1;
    for (int i = 0; i < 3; i++) tick();
    check("starve_uf", underflow_count, 16'd5);
    check("starve_se", sync_err_count, 16'd0);

    // misalignment: 10 non-SOP pixels after reset are discarded
    do_reset();
    src_idx = FPIX - 10; head_data = 24'($urandom);
    sop_force = 24'hABCDEF; sop_force_en = 1; valid_en = 1;
    for (int i = 0; i < 12; i++) tick();
    check("junk_drained", src_idx, 0);
    check("junk_se", sync_err_count, 16'd0);
    run_to(0, 1'b1, "resync_timeout");
    check("resync_pixel", {ltm_r, ltm_g, ltm_b}, 24'hABCDEF);
    check("resync_se", sync_err_count, 16'd0);

    // early SOP right after pixel 50 of the frame
    n = 0;
    while (src_idx != 51 && n < FT) begin tick(); n++; end
    if (n >= FT) check("early_timeout", 32'd0, 32'd1);
    src_idx = 0; head_data = 24'h5A5AA5;
    tick();
    check("early_ready", in_ready, 1'b0);
    check("early_se", sync_err_count, 16'd1);
    run_to(0, 1'b1, "early_origin_timeout");
    check("early_pixel", {ltm_r, ltm_g, ltm_b}, 24'h5A5AA5);

    // randomized stream: valid gaps, stray SOPs, random start
    do_reset();
    rnd_en = 1; valid_en = 1;
    src_idx = $urandom_range(0, FPIX - 1); head_data = 24'($urandom);
    for (int i = 0; i < 12 * FT; i++) tick();
    rnd_en = 0;

    // async reset in the middle of a visible line
    n = 0;
    while (!e_den && n < FT) begin tick(); n++; end
    check("pre_reset_den", ltm_den, 1'b1);
    do_reset();
    tick();
    check("restart_den", ltm_den, 1'b1);
    check("restart_hd", ltm_hd, 1'b1);
    for (int i = 0; i < FT; i++) tick();

    n = 0;
    while (!sat_done && n < 100000) begin @(negedge clk); n++; end
    if (!sat_done) check("sat_thread_timeout", 32'd0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- saturation on dut2 ----------------
  initial begin
    int t, h, v, p, act_cnt, exp;
    reset2_n = 1; valid2 = 0; sop2 = 0; data2 = 24'h00FF00;
    @(negedge clk);
    #2;
    reset2_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset2_n = 1;
    t = 0; act_cnt = 0;
    // SOP seen at clock 0 arms, consumed at origin of frame 1, then starve
    while (act_cnt < 65535 + 64 && t < 90000) begin
      valid2 = (t <= S_FT);
      sop2 = 1'b1;
      p = t % S_FT;
      h = p % S_HT;
      v = p / S_HT;
      @(posedge clk);
      #1;
      if (t > S_FT && h < S_HA && v < S_VA) begin
        act_cnt++;
        exp = (act_cnt > 65535) ? 65535 : act_cnt;
        if (act_cnt == 1 || act_cnt == 5000 || act_cnt == 65534 ||
            act_cnt == 65535 || act_cnt == 65535 + 64)
          check($sformatf("sat_uf_%0d", act_cnt), uf2, exp);
      end
      t++;
      @(negedge clk);
    end
    if (act_cnt < 65535 + 64) check("sat_timeout", 32'd0, 32'd1);
    check("sat_se", se2, 16'd0);
    sat_done = 1;
  end

endmodule
